multi_cycle_cpu: RTL
====================

MULTI_CYCLE_CPU -- requirements
Module: multi_cycle_cpu

Interface
REQ-001 Parameter DATA_WIDTH, default 8: register and memory word width.
REQ-002 Parameter ADDR_BITS, default 5: data memory depth is 2**ADDR_BITS words.
REQ-003 Parameter REG_COUNT, default 4, power of two 2..16: register count; REG_BITS = clog2(REG_COUNT).
REQ-004 Parameter INSTR_WIDTH, default 20: must equal 2 + 3*REG_BITS + IMM_BITS + 4, with IMM_BITS >= ADDR_BITS.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 instr  in  INSTR_WIDTH  instruction word, sampled at accept.
REQ-008 instr_valid  in  1  instr holds a valid instruction.
REQ-009 instr_ready  out  1  core can accept; high only in IDLE.
REQ-010 done  out  1  one-cycle pulse on the edge an instruction retires.
REQ-011 err  out  1  one-cycle pulse alongside done when the retired instruction was illegal.
REQ-012 regs_out  out  REG_COUNT*DATA_WIDTH  all registers, flattened, reg i at bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-013 Instruction fields, MSB first: opcode[2], X1[REG_BITS], X2[REG_BITS], X3[REG_BITS], IMM[IMM_BITS], FUNCT[4].
REQ-014 Opcodes: 00 ADDI (X1 = X2 + IMM), 01 ALU (X1 = X2 op X3), 10 LOAD_R (X1 = MEM[X2+IMM]), 11 STORE_R (MEM[X2+IMM] = X1).
REQ-015 ALU FUNCT: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (unsigned, result 1 or 0); FUNCT 6..15 illegal: no register write, err pulses.
REQ-016 FUNCT is ignored for opcodes 00, 10 and 11.
REQ-017 All arithmetic is modulo 2**DATA_WIDTH; IMM is zero-extended or truncated to DATA_WIDTH.
REQ-018 Memory address is (X2 + IMM) truncated to ADDR_BITS bits, so it wraps at the top of memory.
REQ-019 Accept occurs on an edge where instr_valid and instr_ready are both 1; instr is latched at that edge.
REQ-020 FSM states: IDLE, DECODE, EXEC, MEM, WB.
REQ-021 State transitions: IDLE->DECODE on accept; DECODE->EXEC always; EXEC->WB for ADDI/ALU; EXEC->MEM for LOAD_R/STORE_R; MEM->WB for LOAD_R; MEM->IDLE for STORE_R; WB->IDLE always.
REQ-022 Operands are read in DECODE and the result is registered in EXEC.
REQ-023 The register write occurs on the WB->IDLE edge; the store write occurs on the MEM->IDLE edge; done pulses in the cycle after that edge.
REQ-024 Latency from the accept edge to the write edge: ADDI/ALU 3 cycles, STORE_R 3 cycles, LOAD_R 4 cycles.
REQ-025 instr_valid and instr changes while the core is busy are ignored; the core runs one instruction at a time.
REQ-026 When X1 equals X2 or X3, the old value is read and the new value is written.
REQ-027 Back-to-back instructions are accepted on the first IDLE edge after retire, with no extra gap.

Reset
REQ-028 On rst=0 the FSM goes to IDLE, reg i = i truncated to DATA_WIDTH, all memory words = 0, done = 0, err = 0, and instr_ready = 1 once rst = 1.
REQ-029 Reset asserted mid-instruction aborts it with no register or memory write, and no done pulse.

Structure
REQ-030 Shared package cpu_pkg holds the opcode, FUNCT and FSM state enums and the field-offset helper constants.
REQ-031 Sub-module cpu_alu (combinational, DATA_WIDTH-parametrised, implementing the FUNCT ops) is instantiated once.

Verification
REQ-032 Reset, then ALU 0100011100..0000 (reg0=reg1+reg3) -> reg0=4 at 3 cycles after accept, done pulse, regs [4,1,2,3].
REQ-033 Then ALU reg1=reg0+reg3 -> 7; ALU SUB reg3=reg0-reg2 -> 2; regs [4,7,2,2].
REQ-034 STORE_R MEM[reg2+15]=reg1, then LOAD_R reg3=MEM[reg2+15] -> reg3=7 at 4 cycles after its accept; MEM[17]=7.
REQ-035 ADDI reg2=reg2+30 with reg2=2 gives MEM address (2+30) mod 32=0 for a subsequent STORE_R; also check ADDI 250+10 wraps to 4 at DATA_WIDTH=8.
REQ-036 ALU with FUNCT=9 -> err and done pulse together, regs unchanged; rst=0 during EXEC of an ADD -> no write, regs [0,1,2,3].
REQ-037 Rerun REQ-032 with REG_COUNT=8 and INSTR_WIDTH=23 -> same results; reg7 reset value = 7.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and instruction field helpers for the
//                multi-cycle CPU (opcodes, ALU functions, FSM states).
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int c_OPCODE_BITS = 2;
  localparam int c_FUNCT_BITS  = 4;
  localparam int c_FUNCT_LSB   = 0;
  localparam int c_IMM_LSB     = c_FUNCT_LSB + c_FUNCT_BITS;

  typedef enum logic [1:0] {
    OP_ADDI    = 2'b00,
    OP_ALU     = 2'b01,
    OP_LOAD_R  = 2'b10,
    OP_STORE_R = 2'b11
  } opcode_e;

  typedef enum logic [3:0] {
    FN_ADD = 4'd0,
    FN_SUB = 4'd1,
    FN_AND = 4'd2,
    FN_OR  = 4'd3,
    FN_XOR = 4'd4,
    FN_SLT = 4'd5
  } funct_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  // Immediate width left over once opcode, three register fields and FUNCT are placed
  function automatic int imm_bits(input int instr_width, input int reg_bits);
    return instr_width - c_OPCODE_BITS - 3 * reg_bits - c_FUNCT_BITS;
  endfunction

  function automatic int x3_lsb(input int imm_w);
    return c_IMM_LSB + imm_w;
  endfunction

  function automatic int x2_lsb(input int imm_w, input int reg_bits);
    return x3_lsb(imm_w) + reg_bits;
  endfunction

  function automatic int x1_lsb(input int imm_w, input int reg_bits);
    return x2_lsb(imm_w, reg_bits) + reg_bits;
  endfunction

  function automatic int op_lsb(input int imm_w, input int reg_bits);
    return x1_lsb(imm_w, reg_bits) + reg_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_cycle_cpu_if.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_cpu_if
//  Description : Instruction handshake, retire status and register view
//                between an instruction source (master) and the core (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface multi_cycle_cpu_if #(
  parameter int INSTR_WIDTH = 20,
  parameter int REG_COUNT   = 4,
  parameter int DATA_WIDTH  = 8
);
  logic [INSTR_WIDTH-1:0]          instr;
  logic                            instr_valid;
  logic                            instr_ready;
  logic                            done;
  logic                            err;
  logic [REG_COUNT*DATA_WIDTH-1:0] regs_out;

  modport master (
    output instr, instr_valid,
    input  instr_ready, done, err, regs_out
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, done, err, regs_out
  );
endinterface
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_alu
//  Description : Combinational ALU: ADD, SUB, AND, OR, XOR, unsigned SLT.
//                Unknown function codes flag o_illegal and yield zero.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [3:0]            i_funct,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_illegal
);

  // Function decode; arithmetic wraps naturally at DATA_WIDTH
  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    case (i_funct)
      FN_ADD:  o_result = i_a + i_b;
      FN_SUB:  o_result = i_a - i_b;
      FN_AND:  o_result = i_a & i_b;
      FN_OR:   o_result = i_a | i_b;
      FN_XOR:  o_result = i_a ^ i_b;
      FN_SLT:  o_result = DATA_WIDTH'(i_a < i_b);
      default: o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_cpu
//  Description : Multi-cycle register/memory CPU core. One instruction at a
//                time through IDLE -> DECODE -> EXEC -> (MEM) -> (WB).
//                INSTR_WIDTH must equal 2 + 3*clog2(REG_COUNT) + IMM + 4
//                with IMM >= ADDR_BITS.
//  Revision    : 1.0  initial release
// ============================================================================
module multi_cycle_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BITS   = 5,
  parameter int REG_COUNT   = 4,
  parameter int INSTR_WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  multi_cycle_cpu_if.slave bus
);

  localparam int c_REG_BITS  = $clog2(REG_COUNT);
  localparam int c_IMM_BITS  = imm_bits(INSTR_WIDTH, c_REG_BITS);
  localparam int c_MEM_DEPTH = 2 ** ADDR_BITS;
  localparam int c_X3_LSB    = x3_lsb(c_IMM_BITS);
  localparam int c_X2_LSB    = x2_lsb(c_IMM_BITS, c_REG_BITS);
  localparam int c_X1_LSB    = x1_lsb(c_IMM_BITS, c_REG_BITS);
  localparam int c_OP_LSB    = op_lsb(c_IMM_BITS, c_REG_BITS);

  state_e                  r_state;
  state_e                  w_next_state;
  logic [INSTR_WIDTH-1:0]  r_instr;
  logic [DATA_WIDTH-1:0]   r_regs [REG_COUNT];
  logic [DATA_WIDTH-1:0]   r_mem  [c_MEM_DEPTH];
  logic [DATA_WIDTH-1:0]   r_opa;
  logic [DATA_WIDTH-1:0]   r_opb;
  logic [DATA_WIDTH-1:0]   r_store_data;
  logic [DATA_WIDTH-1:0]   r_result;
  logic                    r_illegal;
  logic                    r_done;
  logic                    r_err;

  opcode_e                 w_opcode;
  logic [c_REG_BITS-1:0]   w_x1;
  logic [c_REG_BITS-1:0]   w_x2;
  logic [c_REG_BITS-1:0]   w_x3;
  logic [c_IMM_BITS-1:0]   w_imm;
  logic [3:0]              w_funct;
  logic [DATA_WIDTH-1:0]   w_imm_ext;
  logic [3:0]              w_alu_funct;
  logic [DATA_WIDTH-1:0]   w_alu_result;
  logic                    w_alu_illegal;
  logic [ADDR_BITS-1:0]    w_addr;
  logic                    w_reg_we;
  logic                    w_mem_we;
  logic                    w_retire;

  // Field extraction from the latched instruction word
  assign w_opcode  = opcode_e'(r_instr[c_OP_LSB +: c_OPCODE_BITS]);
  assign w_x1      = r_instr[c_X1_LSB +: c_REG_BITS];
  assign w_x2      = r_instr[c_X2_LSB +: c_REG_BITS];
  assign w_x3      = r_instr[c_X3_LSB +: c_REG_BITS];
  assign w_imm     = r_instr[c_IMM_LSB +: c_IMM_BITS];
  assign w_funct   = r_instr[c_FUNCT_LSB +: c_FUNCT_BITS];
  assign w_imm_ext = DATA_WIDTH'(w_imm);

  // Non-ALU opcodes reuse the adder for X2 + IMM, so FUNCT never makes them illegal
  assign w_alu_funct = (w_opcode == OP_ALU) ? w_funct : FN_ADD;

  // Address is the DATA_WIDTH sum, wrapped to the memory depth
  assign w_addr = ADDR_BITS'(r_result);

  assign bus.instr_ready = (r_state == S_IDLE);
  assign bus.done        = r_done;
  assign bus.err         = r_err;

  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_regs_out
      assign bus.regs_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
    end
  endgenerate

  cpu_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .i_a       (r_opa),
    .i_b       (r_opb),
    .i_funct   (w_alu_funct),
    .o_result  (w_alu_result),
    .o_illegal (w_alu_illegal)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next state plus the write/retire strobes tied to the terminating edge
  always_comb begin
    w_next_state = r_state;
    w_reg_we     = 1'b0;
    w_mem_we     = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_IDLE:   if (bus.instr_valid) w_next_state = S_DECODE;
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        if (w_opcode == OP_LOAD_R || w_opcode == OP_STORE_R) w_next_state = S_MEM;
        else                                                  w_next_state = S_WB;
      end
      S_MEM: begin
        if (w_opcode == OP_STORE_R) begin
          w_next_state = S_IDLE;
          w_mem_we     = 1'b1;
          w_retire     = 1'b1;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_WB: begin
        w_next_state = S_IDLE;
        w_reg_we     = !r_illegal;
        w_retire     = 1'b1;
      end
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Datapath pipeline registers: latch, operand read, execute, load data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr      <= '0;
      r_opa        <= '0;
      r_opb        <= '0;
      r_store_data <= '0;
      r_result     <= '0;
      r_illegal    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.instr_valid) r_instr <= bus.instr;
      if (r_state == S_DECODE) begin
        r_opa        <= r_regs[w_x2];
        r_opb        <= (w_opcode == OP_ALU) ? r_regs[w_x3] : w_imm_ext;
        r_store_data <= r_regs[w_x1];
      end
      if (r_state == S_EXEC) begin
        r_result  <= w_alu_result;
        r_illegal <= w_alu_illegal;
      end
      if (r_state == S_MEM && w_opcode == OP_LOAD_R) r_result <= r_mem[w_addr];
    end
  end

  // Register file; reset leaves reg i holding i
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= DATA_WIDTH'(i);
    end else if (w_reg_we) begin
      r_regs[w_x1] <= r_result;
    end
  end

  // Data memory, cleared on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < c_MEM_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_mem_we) begin
      r_mem[w_addr] <= r_store_data;
    end
  end

  // Retire pulses, visible the cycle after the write edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_retire;
      r_err  <= w_retire && r_illegal;
    end
  end

endmodule
`default_nettype wire
